// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 constants and decode helpers for the load/store controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TAG_W = 5;

   // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic bad;
      if (we) begin
         bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
      end else begin
         bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return bad;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = a_lo[0];
         F3_W:        mis = (a_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// Combinational byte/half/word select with sign or zero extension for loads.
module load_extend
   import lsu_pkg::*;
#(
   parameter int ADDRESS_LENGTH = 32,
   parameter int WORD_LENGTH    = 8
) (
   input  logic [2:0]                i_funct3,
   input  logic [ADDRESS_LENGTH-1:0] i_word,
   output logic [ADDRESS_LENGTH-1:0] o_result
);

   localparam int HALF_LENGTH = 2 * WORD_LENGTH;

   logic [WORD_LENGTH-1:0] w_byte;
   logic [HALF_LENGTH-1:0] w_half;

   assign w_byte = i_word[WORD_LENGTH-1:0];
   assign w_half = i_word[HALF_LENGTH-1:0];

   // Unknown funct3 yields zero; the controller forces zero for errors anyway.
   always_comb begin
      o_result = '0;
      case (i_funct3)
         F3_B:    o_result = {{(ADDRESS_LENGTH-WORD_LENGTH){w_byte[WORD_LENGTH-1]}}, w_byte};
         F3_H:    o_result = {{(ADDRESS_LENGTH-HALF_LENGTH){w_half[HALF_LENGTH-1]}}, w_half};
         F3_W:    o_result = i_word;
         F3_BU:   o_result = {{(ADDRESS_LENGTH-WORD_LENGTH){1'b0}}, w_byte};
         F3_HU:   o_result = {{(ADDRESS_LENGTH-HALF_LENGTH){1'b0}}, w_half};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, one RAM access cycle, registered response.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | RAM port driven for one cycle; load data sampled at its end
// RESP   | response held until writeback takes it; may accept the next request
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDRESS_LENGTH = 32,
   parameter int WORD_LENGTH    = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_we,
   input  logic [2:0]                i_req_funct3,
   input  logic [ADDRESS_LENGTH-1:0] i_req_addr,
   input  logic [ADDRESS_LENGTH-1:0] i_req_wdata,
   input  logic [TAG_W-1:0]          i_req_rd,
   output logic                      o_resp_valid,
   input  logic                      i_resp_ready,
   output logic [ADDRESS_LENGTH-1:0] o_resp_rdata,
   output logic [TAG_W-1:0]          o_resp_rd,
   output logic                      o_resp_err,
   output logic [ADDRESS_LENGTH-1:0] o_mem_a,
   output logic [ADDRESS_LENGTH-1:0] o_mem_wd,
   output logic                      o_mem_sb,
   output logic                      o_mem_sh,
   output logic                      o_mem_sw,
   input  logic [ADDRESS_LENGTH-1:0] i_mem_rd
);

   logic [1:0]                r_state;
   logic                      r_we;
   logic [2:0]                r_funct3;
   logic [ADDRESS_LENGTH-1:0] r_addr;
   logic [ADDRESS_LENGTH-1:0] r_wdata;
   logic [TAG_W-1:0]          r_rd;
   logic [ADDRESS_LENGTH-1:0] r_resp_rdata;
   logic [TAG_W-1:0]          r_resp_rd;
   logic                      r_resp_err;

   logic                      w_accept;
   logic                      w_err;
   logic                      w_store_go;
   logic [ADDRESS_LENGTH-1:0] w_ext;
   logic [ADDRESS_LENGTH-1:0] w_rdata_next;

   load_extend #(
      .ADDRESS_LENGTH (ADDRESS_LENGTH),
      .WORD_LENGTH    (WORD_LENGTH)
   ) u_load_extend (
      .i_funct3 (r_funct3),
      .i_word   (i_mem_rd),
      .o_result (w_ext)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_err = f3_illegal(r_we, r_funct3) | f3_misaligned(r_funct3, r_addr[1:0]);
`else
   assign w_err = f3_illegal(r_we, r_funct3);
`endif

   always_comb begin
      o_req_ready = 1'b0;
      case (r_state)
         S_IDLE:  o_req_ready = i_rst_n;
         S_RESP:  o_req_ready = i_rst_n & i_resp_ready;
         default: o_req_ready = 1'b0;
      endcase
   end

   assign w_accept     = o_req_ready & i_req_valid;
   assign w_rdata_next = (r_we | w_err) ? '0 : w_ext;

   // Strobes also gated by reset so a reset landing on ACCESS cannot write.
   assign w_store_go = (r_state == S_ACCESS) & i_rst_n & r_we & ~w_err;
   assign o_mem_sb   = w_store_go & (r_funct3 == F3_B);
   assign o_mem_sh   = w_store_go & (r_funct3 == F3_H);
   assign o_mem_sw   = w_store_go & (r_funct3 == F3_W);

   assign o_mem_a      = r_addr;
   assign o_mem_wd     = r_wdata;
   assign o_resp_valid = (r_state == S_RESP);
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_rd    = r_resp_rd;
   assign o_resp_err   = r_resp_err;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd         <= '0;
         r_resp_rdata <= '0;
         r_resp_rd    <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_rd     <= i_req_rd;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               r_resp_rdata <= w_rdata_next;
               r_resp_err   <= w_err;
               r_resp_rd    <= r_rd;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (w_accept)          r_state <= S_ACCESS;
               else if (i_resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed test-plan steps plus random requests against a byte-array model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_sb, mem_sh, mem_sw;
   logic [31:0] mem_rd;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_rd     (req_rd),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_rd    (resp_rd),
      .o_resp_err   (resp_err),
      .o_mem_a      (mem_a),
      .o_mem_wd     (mem_wd),
      .o_mem_sb     (mem_sb),
      .o_mem_sh     (mem_sh),
      .o_mem_sw     (mem_sw),
      .i_mem_rd     (mem_rd)
   );

   // Byte-addressed RAM (4 KiB window, wrapping) with a preload port used during reset.
   logic [7:0]  ram [0:4095];
   logic        bk_we;
   logic [11:0] bk_a;
   logic [7:0]  bk_d;
   logic [11:0] a0, a1, a2, a3;
   assign a0 = mem_a[11:0];
   assign a1 = a0 + 12'd1;
   assign a2 = a0 + 12'd2;
   assign a3 = a0 + 12'd3;
   assign mem_rd = {ram[a3], ram[a2], ram[a1], ram[a0]};

   always @(posedge clk) begin
      if (bk_we) ram[bk_a] <= bk_d;
      if (mem_sb | mem_sh | mem_sw) ram[a0] <= mem_wd[7:0];
      if (mem_sh | mem_sw) ram[a1] <= mem_wd[15:8];
      if (mem_sw) begin
         ram[a2] <= mem_wd[23:16];
         ram[a3] <= mem_wd[31:24];
      end
   end

   int n_sb = 0, n_sh = 0, n_sw = 0, cyc = 0;
   always @(negedge clk) begin
      if (mem_sb === 1'b1) n_sb++;
      if (mem_sh === 1'b1) n_sh++;
      if (mem_sw === 1'b1) n_sw++;
   end
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_exp;
   logic [7:0]  ref_mem [0:4095];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input bit we, input int unsigned f3, input int unsigned a);
      bit bad;
      if (we) bad = (f3 > 2);
      else    bad = (f3 == 3) || (f3 >= 6);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) bad = 1'b1;
      if (f3 == 2 && (a % 4 != 0)) bad = 1'b1;
`endif
      return bad;
   endfunction

   function automatic logic [31:0] model_load(input int unsigned f3, input int unsigned a);
      int unsigned b0, b1, b2, b3, h, w;
      logic [31:0] v;
      b0 = 32'(ref_mem[12'(a)]);
      b1 = 32'(ref_mem[12'(a + 1)]);
      b2 = 32'(ref_mem[12'(a + 2)]);
      b3 = 32'(ref_mem[12'(a + 3)]);
      h  = b0 + 256 * b1;
      w  = h + 65536 * b2 + 16777216 * b3;
      case (f3)
         0: v = (b0 >= 128) ? b0 + 32'hFFFFFF00 : b0;
         1: v = (h >= 32768) ? h + 32'hFFFF0000 : h;
         2: v = w;
         4: v = b0;
         5: v = h;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   // Entered at a negedge with the DUT idle or holding a response; leaves at the response negedge.
   task automatic issue(input bit we, input int unsigned f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      bit          err;
      logic [2:0]  exp_strb;
      int          w;
      int unsigned nbytes;
      req_we     = we;
      req_funct3 = 3'(f3);
      req_addr   = a;
      req_wdata  = wd;
      req_rd     = rd;
      req_valid  = 1'b1;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(posedge clk); @(negedge clk);
         w++;
      end
      chk("req_ready_accept", {31'b0, req_ready}, 32'd1);
      err      = model_err(we, f3, a);
      last_exp = (we || err) ? 32'h0 : model_load(f3, a);
      exp_strb = {we && !err && f3 == 0, we && !err && f3 == 1, we && !err && f3 == 2};
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      chk("access_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("access_req_ready", {31'b0, req_ready}, 32'd0);
      chk("access_mem_a", mem_a, a);
      chk("access_mem_wd", mem_wd, wd);
      chk("access_strobes", {29'b0, mem_sb, mem_sh, mem_sw}, {29'b0, exp_strb});
      if (we && !err) begin
         nbytes = 1 << f3;
         for (int i = 0; i < int'(nbytes); i++) ref_mem[12'(a + i)] = 8'((wd >> (8 * i)) & 32'hFF);
      end
      @(posedge clk); @(negedge clk);
      chk("resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("resp_rdata", resp_rdata, last_exp);
      chk("resp_err", {31'b0, resp_err}, {31'b0, err});
      chk("resp_rd", {27'b0, resp_rd}, {27'b0, rd});
   endtask

   task automatic idle_cycle();
      @(posedge clk); @(negedge clk);
      chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_rd"}, {27'b0, resp_rd}, 32'd0);
      chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
      chk({tag, "_mem_a"}, mem_a, 32'd0);
      chk({tag, "_mem_wd"}, mem_wd, 32'd0);
      chk({tag, "_strobes"}, {29'b0, mem_sb, mem_sh, mem_sw}, 32'd0);
   endtask

   task automatic preload(input int unsigned a, input logic [7:0] d);
      bk_we = 1'b1;
      bk_a  = 12'(a);
      bk_d  = d;
      ref_mem[12'(a)] = d;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sb0, sh0, sw0, c0;
      logic [31:0] held;
      rst_n = 1'b0; resp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      bk_we = 1'b0; bk_a = 12'h0; bk_d = 8'h0;
      @(negedge clk);

      preload(32'h100, 8'h80); preload(32'h101, 8'h7F);
      preload(32'h102, 8'h00); preload(32'h103, 8'hFF);
      for (int i = 0; i < 4; i++) preload(32'h200 + i, 8'($urandom));
      for (int i = 0; i < 4; i++) preload(32'h300 + i, 8'($urandom));
      for (int i = 0; i < 256; i++) preload(32'h400 + i, 8'($urandom));
      bk_we = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      rst_n = 1'b1;
      #1;
      chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

      // Test plan loads from 0x100.
      issue(1'b0, 0, 32'h100, 32'h0, 5'd1);
      chk("lb_const", resp_rdata, 32'hFFFFFF80);
      issue(1'b0, 4, 32'h100, 32'h0, 5'd2);
      chk("lbu_const", resp_rdata, 32'h00000080);
      issue(1'b0, 1, 32'h100, 32'h0, 5'd3);
      chk("lh_const", resp_rdata, 32'h00007F80);
      issue(1'b0, 2, 32'h100, 32'h0, 5'd4);
      chk("lw_const", resp_rdata, 32'hFF007F80);
      issue(1'b0, 5, 32'h100, 32'h0, 5'd5);
      chk("lhu_const", resp_rdata, 32'h00007F80);
      idle_cycle();

      // SB then LW: only byte 0 changes.
      sb0 = n_sb; sh0 = n_sh; sw0 = n_sw;
      held = model_load(2, 32'h200);
      issue(1'b1, 0, 32'h200, 32'hDEADBEEF, 5'd6);
      issue(1'b0, 2, 32'h200, 32'h0, 5'd7);
      chk("sb_word", resp_rdata, {held[31:8], 8'hEF});
      chk("sb_count", 32'(n_sb - sb0), 32'd1);
      chk("sh_count", 32'(n_sh - sh0), 32'd0);
      chk("sw_count", 32'(n_sw - sw0), 32'd0);
      idle_cycle();

      // Four back-to-back loads: acceptance to last response in 8 cycles.
      c0 = cyc;
      for (int i = 0; i < 4; i++) issue(1'b0, 2, 32'h400 + 4 * i, 32'h0, 5'(10 + i));
      chk("b2b_cycles", 32'(cyc - c0), 32'd8);

      // Writeback stall with a pending request.
      held = last_exp;
      resp_ready = 1'b0;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h410; req_rd = 5'd20; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
         chk("stall_rdata", resp_rdata, held);
         chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      issue(1'b0, 2, 32'h410, 32'h0, 5'd20);

      // Reset lands on the ACCESS cycle of a SW.
      sw0 = n_sw;
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h12345678;
      req_rd = 5'd21; req_valid = 1'b1;
      chk("rst_sw_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_access_strobes", {29'b0, mem_sb, mem_sh, mem_sw}, 32'd0);
      @(posedge clk); @(negedge clk);
      check_reset_outputs("midrst");
      chk("midrst_sw_count", 32'(n_sw - sw0), 32'd0);
      rst_n = 1'b1;
      #1;
      issue(1'b0, 2, 32'h300, 32'h0, 5'd22);

      // Illegal funct3.
      issue(1'b0, 3, 32'h100, 32'h0, 5'd23);
      chk("illegal_ld_err", {31'b0, resp_err}, 32'd1);
      chk("illegal_ld_rdata", resp_rdata, 32'd0);
      sb0 = n_sb; sh0 = n_sh; sw0 = n_sw;
      issue(1'b1, 5, 32'h204, 32'hCAFEF00D, 5'd24);
      chk("illegal_st_err", {31'b0, resp_err}, 32'd1);
      chk("illegal_st_strobes", 32'((n_sb - sb0) + (n_sh - sh0) + (n_sw - sw0)), 32'd0);

      // Misaligned SW.
      sw0 = n_sw;
      issue(1'b1, 2, 32'h202, 32'hA5A55A5A, 5'd25);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_sw_err", {31'b0, resp_err}, 32'd1);
      chk("mis_sw_count", 32'(n_sw - sw0), 32'd0);
`else
      chk("mis_sw_err", {31'b0, resp_err}, 32'd0);
      chk("mis_sw_count", 32'(n_sw - sw0), 32'd1);
`endif
      issue(1'b0, 2, 32'h200, 32'h0, 5'd26);
      issue(1'b0, 1, 32'h203, 32'h0, 5'd27);
      idle_cycle();

      // Random traffic in the preloaded window.
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom), $urandom % 8, 32'h400 + ($urandom % 32'hFC), $urandom, 5'($urandom));
         if ($urandom % 4 == 0) idle_cycle();
      end
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
